// File: rtl/mem_test_pkg.sv
// rtl/mem_test_pkg.sv - shared types, constants and LFSR step for the SDRAM memory test master
package mem_test_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_GAP,
        RD_REQ,
        RD_GAP,
        DONE
    } state_t;

    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
    localparam logic [3:0]  WSTRB_WR  = 4'hF;
    localparam logic [3:0]  WSTRB_RD  = 4'h0;

    // Galois LFSR, right-shifting: feedback from bit 0 folds the polynomial in.
    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
    endfunction

endpackage

// File: rtl/mem_test_master_if.sv
// rtl/mem_test_master_if.sv - valid/ready memory port between the test master and the SDRAM controller
interface mem_test_master_if;

    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_addr;
    logic [31:0] o_wdata;
    logic [3:0]  o_wstrb;
    logic [31:0] i_rdata;

    modport master (
        output o_valid,
        output o_addr,
        output o_wdata,
        output o_wstrb,
        input  i_ready,
        input  i_rdata
    );

    modport slave (
        input  o_valid,
        input  o_addr,
        input  o_wdata,
        input  o_wstrb,
        output i_ready,
        output i_rdata
    );

endinterface

// File: rtl/mem_test_lfsr.sv
// rtl/mem_test_lfsr.sv - 32-bit pattern generator with synchronous load and advance
module mem_test_lfsr
    import mem_test_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load,
    input  logic [31:0] seed,
    input  logic        adv,
    output logic [31:0] q
);

    // Reset lands on the seed so the first write after start already has its pattern.
    always_ff @(posedge clk_i) begin
        if (rst_i || load) begin
            q <= seed;
        end else if (adv) begin
            q <= lfsr_next(q);
        end
    end

endmodule

// File: rtl/mem_test_master.sv
// rtl/mem_test_master.sv - SDRAM write/readback LFSR test initiator; MEM_TEST_TIMEOUT_EN adds a request watchdog
module mem_test_master
    import mem_test_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
    parameter int unsigned WORDS     = 1024,
    parameter logic [31:0] SEED      = 32'h1234_5678,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               pass_o,
    output logic [15:0]        err_cnt_o,
    output logic [31:0]        first_err_addr_o,
    output logic               timeout_o,
    mem_test_master_if.master  bus
);

    state_t      state;
    logic [31:0] idx;
    logic [31:0] idx_inc;
    logic [31:0] lfsr_q;
    logic        last_word;
    logic        start_ok;
    logic        lfsr_load;
    logic        lfsr_adv;

    assign idx_inc   = idx + 32'd1;
    assign last_word = (idx == 32'(WORDS - 1));
    assign start_ok  = start_i && ((state == IDLE) || (state == DONE));
    assign lfsr_load = start_ok || ((state == WR_GAP) && last_word);
    assign lfsr_adv  = bus.o_valid && bus.i_ready && ((state == WR_REQ) || (state == RD_REQ));

    mem_test_lfsr u_lfsr (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .load  (lfsr_load),
        .seed  (SEED),
        .adv   (lfsr_adv),
        .q     (lfsr_q)
    );

`ifdef MEM_TEST_TIMEOUT_EN
    localparam int WD_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    logic [WD_W-1:0] wd_cnt;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state            <= IDLE;
            idx              <= 32'd0;
            busy_o           <= 1'b0;
            done_o           <= 1'b0;
            pass_o           <= 1'b0;
            err_cnt_o        <= 16'd0;
            first_err_addr_o <= 32'd0;
            timeout_o        <= 1'b0;
            bus.o_valid      <= 1'b0;
            bus.o_addr       <= 32'd0;
            bus.o_wdata      <= 32'd0;
            bus.o_wstrb      <= 4'h0;
`ifdef MEM_TEST_TIMEOUT_EN
            wd_cnt           <= '0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start_i) begin
                        state            <= WR_REQ;
                        idx              <= 32'd0;
                        busy_o           <= 1'b1;
                        done_o           <= 1'b0;
                        pass_o           <= 1'b0;
                        err_cnt_o        <= 16'd0;
                        first_err_addr_o <= 32'd0;
                        timeout_o        <= 1'b0;
                        bus.o_valid      <= 1'b1;
                        bus.o_addr       <= ADDR_BASE;
                        bus.o_wdata      <= SEED;
                        bus.o_wstrb      <= WSTRB_WR;
`ifdef MEM_TEST_TIMEOUT_EN
                        wd_cnt           <= '0;
`endif
                    end
                end
                WR_REQ, RD_REQ: begin
                    if (bus.i_ready) begin
                        bus.o_valid <= 1'b0;
                        state       <= (state == WR_REQ) ? WR_GAP : RD_GAP;
                        if ((state == RD_REQ) && (bus.i_rdata != lfsr_q)) begin
                            if (err_cnt_o != 16'hFFFF) begin
                                err_cnt_o <= err_cnt_o + 16'd1;
                            end
                            if (err_cnt_o == 16'd0) begin
                                first_err_addr_o <= bus.o_addr;
                            end
                        end
`ifdef MEM_TEST_TIMEOUT_EN
                    end else if (wd_cnt == WD_W'(TIMEOUT - 1)) begin
                        bus.o_valid <= 1'b0;
                        timeout_o   <= 1'b1;
                        state       <= DONE;
                        busy_o      <= 1'b0;
                        done_o      <= 1'b1;
                        pass_o      <= 1'b0;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
`endif
                    end
                end
                WR_GAP: begin
                    bus.o_valid <= 1'b1;
`ifdef MEM_TEST_TIMEOUT_EN
                    wd_cnt      <= '0;
`endif
                    if (last_word) begin
                        state       <= RD_REQ;
                        idx         <= 32'd0;
                        bus.o_addr  <= ADDR_BASE;
                        bus.o_wdata <= 32'd0;
                        bus.o_wstrb <= WSTRB_RD;
                    end else begin
                        state       <= WR_REQ;
                        idx         <= idx_inc;
                        bus.o_addr  <= ADDR_BASE + {idx_inc[29:0], 2'b00};
                        bus.o_wdata <= lfsr_q;
                    end
                end
                RD_GAP: begin
                    idx <= idx_inc;
                    if (last_word) begin
                        state  <= DONE;
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                        pass_o <= (err_cnt_o == 16'd0) && !timeout_o;
                    end else begin
                        state       <= RD_REQ;
                        bus.o_valid <= 1'b1;
                        bus.o_addr  <= ADDR_BASE + {idx_inc[29:0], 2'b00};
`ifdef MEM_TEST_TIMEOUT_EN
                        wd_cnt      <= '0;
`endif
                    end
                end
                default: begin
                    state       <= IDLE;
                    bus.o_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_test_master.sv
// tb/tb_mem_test_master.sv - table-driven scoreboard bench for mem_test_master with a behavioural slave
module tb_mem_test_master;

    localparam logic [31:0] ADDR_BASE = 32'h0000_0000;
    localparam int          WORDS     = 4;
    localparam logic [31:0] SEED      = 32'h1234_5678;
    localparam int          TIMEOUT   = 16;
    localparam logic [31:0] POLY      = 32'h8020_0003;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic        busy_o;
    logic        done_o;
    logic        pass_o;
    logic [15:0] err_cnt_o;
    logic [31:0] first_err_addr_o;
    logic        timeout_o;

    mem_test_master_if bus ();

    mem_test_master #(
        .ADDR_BASE (ADDR_BASE),
        .WORDS     (WORDS),
        .SEED      (SEED),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .start_i          (start_i),
        .busy_o           (busy_o),
        .done_o           (done_o),
        .pass_o           (pass_o),
        .err_cnt_o        (err_cnt_o),
        .first_err_addr_o (first_err_addr_o),
        .timeout_o        (timeout_o),
        .bus              (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } xfer_t;

    typedef struct {
        int          delay_max;
        logic [3:0]  flip;
        logic [15:0] exp_err;
        logic [31:0] exp_first;
        logic        exp_pass;
    } vec_t;

    xfer_t       sb[$];
    logic [31:0] mem [WORDS];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          xfer_cnt = 0;
    int          delay_max = 0;
    logic [3:0]  flip_mask = 4'h0;
    bit          never_ready = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_step(input logic [31:0] s);
        logic [31:0] sh;
        sh = {1'b0, s[31:1]};
        return s[0] ? (sh ^ POLY) : sh;
    endfunction

    task automatic push_expected();
        logic [31:0] s;
        xfer_t       x;
        s = SEED;
        for (int i = 0; i < WORDS; i++) begin
            x.addr = ADDR_BASE + 32'(4 * i); x.wstrb = 4'hF; x.wdata = s;
            sb.push_back(x);
            s = model_step(s);
        end
        for (int i = 0; i < WORDS; i++) begin
            x.addr = ADDR_BASE + 32'(4 * i); x.wstrb = 4'h0; x.wdata = 32'h0;
            sb.push_back(x);
        end
    endtask

    // Behavioural slave: decides i_ready mid-cycle, checks handshake rules and the scoreboard.
    initial begin
        bit          prev_wait = 1'b0;
        bit          prev_hs = 1'b0;
        bit          gap_pending = 1'b0;
        int          wait_cnt = 0;
        int          widx;
        logic [31:0] s_addr, s_wdata;
        logic [3:0]  s_wstrb;
        xfer_t       e;
        bus.i_ready = 1'b0;
        bus.i_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (prev_hs) begin
                chk("gap_low", 32'(bus.o_valid), 32'd0);
                prev_hs = 1'b0;
                gap_pending = 1'b1;
            end else if (gap_pending) begin
                if (busy_o) chk("gap_one_cycle", 32'(bus.o_valid), 32'd1);
                gap_pending = 1'b0;
            end
            if (rst_i || !bus.o_valid) begin
                bus.i_ready = 1'b0;
                wait_cnt = (delay_max == 0) ? 0 : $urandom_range(delay_max, 0);
                prev_wait = 1'b0;
            end else begin
                if (prev_wait) begin
                    chk("hold_addr", bus.o_addr, s_addr);
                    chk("hold_wdata", bus.o_wdata, s_wdata);
                    chk("hold_wstrb", 32'(bus.o_wstrb), 32'(s_wstrb));
                end
                if (never_ready || wait_cnt != 0) begin
                    if (wait_cnt != 0) wait_cnt--;
                    bus.i_ready = 1'b0;
                    prev_wait = 1'b1;
                    s_addr = bus.o_addr; s_wdata = bus.o_wdata; s_wstrb = bus.o_wstrb;
                end else begin
                    bus.i_ready = 1'b1;
                    prev_wait = 1'b0;
                    prev_hs = 1'b1;
                    xfer_cnt++;
                    widx = int'((bus.o_addr - ADDR_BASE) >> 2) % WORDS;
                    if (bus.o_wstrb == 4'hF) mem[widx] = bus.o_wdata;
                    else bus.i_rdata = mem[widx] ^ {31'd0, flip_mask[widx]};
                    if (sb.size() == 0) begin
                        chk("sb_underflow", 32'(sb.size()), 32'd1);
                    end else begin
                        e = sb.pop_front();
                        chk("xfer_addr", bus.o_addr, e.addr);
                        chk("xfer_wstrb", 32'(bus.o_wstrb), 32'(e.wstrb));
                        if (e.wstrb == 4'hF) chk("xfer_wdata", bus.o_wdata, e.wdata);
                    end
                end
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk); start_i = 1'b1;
        @(negedge clk); start_i = 1'b0;
    endtask

    task automatic wait_done(output int cycles);
        cycles = 1;
        while (!done_o && cycles < 2000) begin
            @(negedge clk);
            cycles++;
        end
        if (!done_o) chk("done_wait_expired", 32'(done_o), 32'd1);
    endtask

    task automatic check_result(input string tag, input logic [15:0] err, input logic [31:0] first,
                                input logic pass);
        chk({tag, "_done"}, 32'(done_o), 32'd1);
        chk({tag, "_busy"}, 32'(busy_o), 32'd0);
        chk({tag, "_pass"}, 32'(pass_o), 32'(pass));
        chk({tag, "_err_cnt"}, 32'(err_cnt_o), 32'(err));
        chk({tag, "_first_err"}, first_err_addr_o, first);
        chk({tag, "_timeout"}, 32'(timeout_o), 32'd0);
        chk({tag, "_valid_idle"}, 32'(bus.o_valid), 32'd0);
        chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        vec_t vecs[5];
        int   cycles;
        int   x0;
        int   guard;

        vecs[0] = '{delay_max: 0, flip: 4'b0000, exp_err: 16'd0, exp_first: 32'h0, exp_pass: 1'b1};
        vecs[1] = '{delay_max: 0, flip: 4'b0100, exp_err: 16'd1, exp_first: 32'h8, exp_pass: 1'b0};
        vecs[2] = '{delay_max: 0, flip: 4'b1010, exp_err: 16'd2, exp_first: 32'h4, exp_pass: 1'b0};
        vecs[3] = '{delay_max: 5, flip: 4'b0000, exp_err: 16'd0, exp_first: 32'h0, exp_pass: 1'b1};
        vecs[4] = '{delay_max: 5, flip: 4'b0001, exp_err: 16'd1, exp_first: 32'h0, exp_pass: 1'b0};

        rst_i = 1'b1;
        start_i = 1'b0;
        repeat (3) @(negedge clk);
        rst_i = 1'b0;
        @(negedge clk);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_pass", 32'(pass_o), 32'd0);
        chk("rst_err_cnt", 32'(err_cnt_o), 32'd0);
        chk("rst_first_err", first_err_addr_o, 32'd0);
        chk("rst_valid", 32'(bus.o_valid), 32'd0);
        chk("rst_addr", bus.o_addr, 32'd0);
        chk("rst_wstrb", 32'(bus.o_wstrb), 32'd0);

        for (int v = 0; v < 5; v++) begin
            delay_max = vecs[v].delay_max;
            flip_mask = vecs[v].flip;
            push_expected();
            pulse_start();
            chk("start_valid", 32'(bus.o_valid), 32'd1);
            chk("start_addr", bus.o_addr, ADDR_BASE);
            chk("start_busy", 32'(busy_o), 32'd1);
            wait_done(cycles);
            if (vecs[v].delay_max == 0) chk("latency_cycles", 32'(cycles), 32'(4 * WORDS + 1));
            check_result("vec", vecs[v].exp_err, vecs[v].exp_first, vecs[v].exp_pass);
        end

        // Reset while a write request is pending, then a clean rerun.
        delay_max = 3;
        flip_mask = 4'h0;
        push_expected();
        pulse_start();
        guard = 0;
        while (!(bus.o_valid && bus.o_addr == ADDR_BASE + 32'h4) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        chk("mid_rst_reached", 32'(bus.o_valid), 32'd1);
        rst_i = 1'b1;
        @(negedge clk);
        chk("mid_rst_valid", 32'(bus.o_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy_o), 32'd0);
        chk("mid_rst_done", 32'(done_o), 32'd0);
        chk("mid_rst_addr", bus.o_addr, 32'd0);
        chk("mid_rst_wdata", bus.o_wdata, 32'd0);
        chk("mid_rst_wstrb", 32'(bus.o_wstrb), 32'd0);
        rst_i = 1'b0;
        sb.delete();
        @(negedge clk);
        push_expected();
        pulse_start();
        wait_done(cycles);
        check_result("post_rst", 16'd0, 32'h0, 1'b1);

        // A start pulse in the read phase must not disturb the running test.
        delay_max = 2;
        x0 = xfer_cnt;
        push_expected();
        pulse_start();
        guard = 0;
        while (!(bus.o_valid && bus.o_wstrb == 4'h0) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        chk("rd_phase_reached", 32'(bus.o_wstrb == 4'h0), 32'd1);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        wait_done(cycles);
        repeat (4) @(negedge clk);
        chk("busy_start_xfers", 32'(xfer_cnt - x0), 32'(2 * WORDS));
        check_result("busy_start", 16'd0, 32'h0, 1'b1);

`ifdef MEM_TEST_TIMEOUT_EN
        // Watchdog: slave never answers the first write.
        never_ready = 1'b1;
        delay_max = 0;
        pulse_start();
        cycles = 1;
        while (bus.o_valid && cycles < 200) begin
            @(negedge clk);
            cycles++;
        end
        chk("wd_valid_cycles", 32'(cycles - 1), 32'(TIMEOUT));
        chk("wd_timeout", 32'(timeout_o), 32'd1);
        chk("wd_done", 32'(done_o), 32'd1);
        chk("wd_pass", 32'(pass_o), 32'd0);
        chk("wd_busy", 32'(busy_o), 32'd0);
        never_ready = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_test_master.md
Name: mem_test_master

Overview:
- Initiator (bus master) for the on-chip SDRAM controller's valid/ready memory port.
- Drives the port that the controller answers: i_valid, i_addr, i_wdata, i_wstrb out; o_ready, o_rdata in.
- On a start pulse, writes a 32-bit LFSR pattern over a word range, then reads it back and compares.
- Reports pass/fail, error count and first failing address. Used for board bring-up of the SDRAM on the 133 MHz domain.

Parameters:
- ADDR_BASE, 32'h0000_0000, byte address of the first word (must be 4-byte aligned).
- WORDS, 1024, number of 32-bit words tested; must be >= 1.
- SEED, 32'h1234_5678, LFSR seed; must be non-zero.
- TIMEOUT, 255, maximum cycles o_valid may wait for i_ready (used only with the optional feature).

Ports:
- clk_i  in  1  single clock (clk_133 domain).
- rst_i  in  1  synchronous reset, active-high.
- start_i  in  1  one-cycle start pulse.
- busy_o  out  1  test in progress.
- done_o  out  1  test finished; held until next accepted start.
- pass_o  out  1  valid while done_o=1; 1 = no mismatch and no timeout.
- err_cnt_o  out  16  mismatch count, saturating at 16'hFFFF.
- first_err_addr_o  out  32  address of the first mismatch.
- timeout_o  out  1  test aborted by the watchdog.
- o_valid  out  1  request valid.
- i_ready  in  1  request accepted / read data valid.
- o_addr  out  32  byte address.
- o_wdata  out  32  write data.
- o_wstrb  out  4  4'hF = write, 4'h0 = read.
- i_rdata  in  32  read data, sampled when o_valid & i_ready on a read.

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is synchronous and active-high. All state is sampled on the rising edge of clk_i.
- Reset values: all outputs 0; state IDLE; LFSR = SEED; word index = 0.
- Handshake:
  - A transfer completes on a cycle with o_valid=1 and i_ready=1.
  - While o_valid=1 and i_ready=0, o_addr, o_wdata and o_wstrb are held stable.
  - After each completion, o_valid is low for exactly one cycle before the next request.
- LFSR:
  - Galois form, polynomial 32'h8020_0003, advanced once per completed transfer.
  - Reloaded with SEED at the start of the write phase and again at the start of the read phase.
- Address: ADDR_BASE + 4*idx, idx = 0..WORDS-1. The index is 32 bits wide; no wrap inside a phase.
- State machine:
  - IDLE: start_i=1 -> WR_REQ. Clear err_cnt_o, first_err_addr_o, done_o, pass_o, timeout_o. Set busy_o=1.
  - WR_REQ: o_valid=1, o_wstrb=4'hF, o_wdata=LFSR. On handshake -> WR_GAP.
  - WR_GAP: o_valid=0. Increment idx. If idx was WORDS-1 -> RD_REQ with idx=0 and LFSR=SEED; else -> WR_REQ.
  - RD_REQ: o_valid=1, o_wstrb=4'h0. On handshake, compare i_rdata with LFSR. On mismatch, err_cnt_o increments (saturating) at that edge, and first_err_addr_o is captured if err_cnt_o was 0. -> RD_GAP.
  - RD_GAP: o_valid=0. Increment idx. If last word -> DONE; else -> RD_REQ.
  - DONE: busy_o=0, done_o=1, pass_o=(err_cnt_o==0 && !timeout_o). start_i=1 -> restart as from IDLE.
- Latency:
  - start_i at edge N -> o_valid=1 with o_addr=ADDR_BASE from cycle N+1.
  - With zero-wait responses, a test takes 4*WORDS+1 cycles from start_i to done_o.
- start_i while busy_o=1 is ignored.
- rst_i mid-transfer drops o_valid at the next edge. Outstanding requests are abandoned; the slave must tolerate a valid withdrawn by reset.
- i_ready while o_valid=0 is ignored.

Optional Feature:
- MEM_TEST_TIMEOUT_EN defined:
  - An 8+ bit counter clears on every rising edge of o_valid and counts cycles in WR_REQ/RD_REQ with i_ready=0.
  - On reaching TIMEOUT, at the next edge: o_valid=0, timeout_o=1, state -> DONE, pass_o=0.
- Undefined: no watchdog; timeout_o tied 0; the master waits indefinitely.

Decomposition:
- Package mem_test_pkg holds:
  - state enum (IDLE, WR_REQ, WR_GAP, RD_REQ, RD_GAP, DONE)
  - LFSR_POLY = 32'h8020_0003
  - WSTRB_WR = 4'hF and WSTRB_RD = 4'h0
  - function lfsr_next.
- One sub-module: mem_test_lfsr (load, advance, 32-bit state). Ports: clk_i, rst_i, load, seed, adv, q.

Test Plan:
- Ideal slave, ready one cycle after valid, WORDS=4 -> 8 transfers. Addresses 0,4,8,C written then read. done_o=1, pass_o=1, err_cnt_o=0.
- Slave flips bit 0 of the word at address 8 on read -> err_cnt_o=1, first_err_addr_o=32'h8, pass_o=0. Errors on words 1 and 3 -> count 2, first addr 4.
- Slave with random 0-5 cycle ready delay -> o_addr/o_wdata/o_wstrb are stable throughout each wait, and there is one idle cycle between transfers.
- MEM_TEST_TIMEOUT_EN, TIMEOUT=16, slave never ready -> o_valid drops, timeout_o=1 and done_o=1 exactly 16 cycles after o_valid rose; pass_o=0.
- rst_i asserted while o_valid=1 in the write phase -> next cycle all outputs 0. A subsequent start_i runs the full test and passes.
- start_i pulsed during the read phase -> ignored: transfer count and result unchanged.
